seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter CNT_W, default 8, width of the match counter (legal range 2..16).
REQ-002 Port: clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Port: bit_valid  input  1  qualifies bit_in; a bit is accepted only on an edge where bit_valid=1.
REQ-005 Port: bit_in  input  1  serial data, fed from the upstream sequence generator's y_out.
REQ-006 Port: clr_cnt  input  1  synchronous clear of match_cnt.
REQ-007 Port: match  output  1  one-cycle pulse for each detected occurrence of 1011.
REQ-008 Port: match_cnt  output  CNT_W  saturating count of detected occurrences.
REQ-009 Port: state  output  3  current detector state, for debug and monitoring.

Function
REQ-010 The block SHALL detect the serial pattern 1011, with the first-received bit leftmost, as a Moore FSM with 3-bit state encoding S0=000, S1=001, S10=010, S101=011, S1011=100.
REQ-011 The FSM SHALL follow these transitions, written as state: bit_in=0 -> / bit_in=1 ->:
- S0: 0 -> S0 / 1 -> S1.
- S1: 0 -> S10 / 1 -> S1.
- S10: 0 -> S0 / 1 -> S101.
- S101: 0 -> S10 / 1 -> S1011.
- S1011: 0 -> see REQ-025 / 1 -> S1.
REQ-012 The state SHALL hold on any edge where bit_valid=0.
REQ-013 Unused encodings 101..111 SHALL return to S0 on the next edge, regardless of bit_valid.
REQ-014 match SHALL be registered and SHALL be 1 for exactly the one cycle following the edge that accepts a bit moving the FSM into S1011 (latency 1 cycle).
REQ-015 match SHALL be 0 in every other cycle, including while the FSM holds in S1011 with bit_valid=0.
REQ-016 match_cnt SHALL increment by 1 on the same edge that sets match.
REQ-017 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 When clr_cnt=1, match_cnt SHALL become 0 on that edge, overriding any simultaneous increment.
REQ-019 clr_cnt SHALL NOT affect state or match.
REQ-020 The state output SHALL always equal the internal state register.

Reset
REQ-021 When reset=0 at a rising edge, state SHALL become S0, match 0 and match_cnt 0.
REQ-022 Reset SHALL take priority over bit_valid and clr_cnt.
REQ-023 Reset applied mid-pattern SHALL discard the partial match; no bits accepted before the reset edge contribute to a later match.
REQ-024 No output SHALL change asynchronously to clk.

Configuration
REQ-025 Macro SEQ_DETECTOR_OVERLAP_EN selects the S1011 exit on bit_in=0:
- Defined: S1011 goes to S10, giving overlapping detection.
- Undefined: S1011 goes to S0, giving non-overlapping detection.
All other behaviour is identical in both builds.

Structure
REQ-026 Package seq_detector_pkg SHALL hold:
- the 3-bit state typedef and the five state encoding constants;
- the PATTERN constant 4'b1011.
REQ-027 Sub-module seq_detector_fsm SHALL contain the state register, the next-state logic and match generation.
REQ-028 The top level SHALL instantiate seq_detector_fsm and SHALL implement the counter.

Verification
REQ-029 Overlap build, valid=1, bits 1,0,1,1,0,1,1 -> match pulses one cycle after the 4th and the 7th bit; match_cnt=2.
REQ-030 Non-overlap build, same stream -> exactly one match pulse, after the 4th bit; match_cnt=1; state=S1 at the end.
REQ-031 Bits 1,0,1, then reset=0 for one cycle, then bit 1 -> no match pulse; state=S1; match_cnt=0.
REQ-032 Stream 1,0,1,1 with bit_valid=0 for 3 cycles between each pair of bits -> exactly one one-cycle match pulse, after the last valid bit; the held S1011 cycles produce no further pulses.
REQ-033 CNT_W=2, five separate 1011 occurrences -> match_cnt reads 1, 2, 3, 3, 3.
REQ-034 clr_cnt=1 on the same edge as a match -> match pulses; match_cnt=0.
REQ-035 Force state=110 -> state=S0 after one edge, with bit_valid=0.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
// The overlap option is selected by the SEQ_DETECTOR_OVERLAP_EN macro in seq_detector_fsm.
package seq_detector_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S0    = 3'b000;
    localparam state_t S1    = 3'b001;
    localparam state_t S10   = 3'b010;
    localparam state_t S101  = 3'b011;
    localparam state_t S1011 = 3'b100;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector_fsm.sv
// Moore FSM recognising 1011 (first bit leftmost) with a registered one-cycle match pulse.
// Define SEQ_DETECTOR_OVERLAP_EN to let a completed pattern seed the next one.
module seq_detector_fsm
    import seq_detector_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bit_valid,
    input  logic   bit_in,
    output logic   match,
    output logic   match_set,
    output state_t state
);

    state_t state_reg;
    state_t state_next;
    logic   match_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S0:    if (bit_valid) state_next = bit_in ? S1    : S0;
            S1:    if (bit_valid) state_next = bit_in ? S1    : S10;
            S10:   if (bit_valid) state_next = bit_in ? S101  : S0;
            S101:  if (bit_valid) state_next = bit_in ? S1011 : S10;
`ifdef SEQ_DETECTOR_OVERLAP_EN
            S1011: if (bit_valid) state_next = bit_in ? S1    : S10;
`else
            S1011: if (bit_valid) state_next = bit_in ? S1    : S0;
`endif
            default: state_next = S0;
        endcase
    end

    // Only a freshly accepted bit can enter S1011, so holding there never re-pulses.
    assign match_set = bit_valid && (state_next == S1011);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S0;
            match_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            match_reg <= match_set;
        end
    end

    assign match = match_reg;
    assign state = state_reg;

endmodule

// File: rtl/seq_detector.sv
// Top level: 1011 detector FSM plus a saturating, clearable match counter.
// Overlapping detection is enabled by defining SEQ_DETECTOR_OVERLAP_EN.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             match_set;
    logic [CNT_W-1:0] cnt_reg;

    seq_detector_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .match     (match),
        .match_set (match_set),
        .state     (state)
    );

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (match_set && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: a default-width and a CNT_W=2 instance share one stimulus.
// Expectations follow the build's SEQ_DETECTOR_OVERLAP_EN setting.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic       clr_cnt;
    logic       m8, m2;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [2:0] s8, s2;

    int pass_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    seq_detector dut8 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clr_cnt(clr_cnt), .match(m8), .match_cnt(c8), .state(s8)
    );

    seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clr_cnt(clr_cnt), .match(m2), .match_cnt(c2), .state(s2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic rst, input logic v, input logic b, input logic c);
        reset     = rst;
        bit_valid = v;
        bit_in    = b;
        clr_cnt   = c;
        @(posedge clk);
        @(negedge clk);
        $display("step rst=%0b v=%0b b=%0b clr=%0b -> state=%0d match=%0b cnt8=%0d cnt2=%0d",
                 rst, v, b, c, s8, m8, c8, c2);
    endtask

    int stream [7] = '{1, 0, 1, 1, 0, 1, 1};
`ifdef SEQ_DETECTOR_OVERLAP_EN
    int exp_m  [7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp_s  [7] = '{1, 2, 3, 4, 2, 3, 4};
    int exp_c  = 2;
`else
    int exp_m  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int exp_s  [7] = '{1, 2, 3, 4, 0, 1, 1};
    int exp_c  = 1;
`endif
    int pat    [4] = '{1, 0, 1, 1};
    int sat2   [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);

        // Reset state, with valid and clear active to show reset priority
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("reset_state", s8, 0);
        chk("reset_match", m8, 0);
        chk("reset_cnt",   c8, 0);

        // Seven-bit stream: overlap behaviour depends on the build
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'(stream[i]), 1'b0);
            chk($sformatf("stream_match_%0d", i), m8, exp_m[i]);
            chk($sformatf("stream_state_%0d", i), s8, exp_s[i]);
        end
        chk("stream_cnt", c8, exp_c);

        // Clear leaves state and match untouched
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", c8, 0);
        chk("clr_state_hold", s8, exp_s[6]);
        chk("clr_match", m8, 0);

        // Reset mid-pattern discards 1,0,1
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_pre_state", s8, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_reset_state", s8, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_after_match", m8, 0);
        chk("mid_after_state", s8, 1);
        chk("mid_after_cnt",   c8, 0);

        // Sparse valid: three idle cycles between bits
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'(pat[i]), 1'b0);
            chk($sformatf("sparse_match_bit%0d", i), m8, (i == 3) ? 1 : 0);
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 1'b0, 1'(1 - pat[i]), 1'b0);
                chk($sformatf("sparse_idle_match_%0d_%0d", i, k), m8, 0);
                chk($sformatf("sparse_idle_state_%0d_%0d", i, k), s8, (i == 3) ? 4 : i + 1);
            end
        end
        chk("sparse_cnt", c8, 1);

        // Saturation on the 2-bit instance; the 8-bit one keeps counting
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'(pat[i]), 1'b0);
            chk($sformatf("sat_cnt2_%0d", n), c2, sat2[n]);
            chk($sformatf("sat_cnt8_%0d", n), c8, n + 1);
            chk($sformatf("sat_match2_%0d", n), m2, 1);
        end
        chk("sat_state2", s2, 4);

        // Clear on the match edge: pulse still appears, count goes to zero
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_on_match_match", m8, 1);
        chk("clr_on_match_cnt8",  c8, 0);
        chk("clr_on_match_cnt2",  c2, 0);

        // Illegal encoding recovers to S0 even with bit_valid low
        bit_valid = 1'b0;
        force dut8.u_fsm.state_reg = 3'b110;
        #1;
        release dut8.u_fsm.state_reg;
        chk("illegal_forced", s8, 6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("illegal_recover", s8, 0);
        chk("illegal_match", m8, 0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
